// File: rtl/mesm6_useq.sv
// rtl/mesm6_useq.sv - MESM-6 microprogram sequencer
// Registered uop/upc with stall, dispatch, irq entry, call stack and loop counter.
module mesm6_useq #(
  parameter int UPC_BITS    = 8,
  parameter int UOP_BITS    = 64,
  parameter int NCOND       = 8,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_BITS    = 8,
  parameter int RESET_ADDR  = 1,
  parameter int INT_ADDR    = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               busy,
  output logic [UPC_BITS-1:0]                uop_rom_addr,
  input  logic [UOP_BITS-1:0]                uop_rom_data,
  output logic [UOP_BITS-1:0]                uop,
  output logic [UPC_BITS-1:0]                upc,
  input  logic [2:0]                         seq_op,
  input  logic [UPC_BITS-1:0]                seq_imm,
  input  logic [NCOND-1:0]                   cond_mask,
  input  logic                               cond_neg,
  input  logic [NCOND-1:0]                   cond_in,
  input  logic                               irq,
  input  logic [UPC_BITS-1:0]                decode_addr,
  output logic                               irq_taken,
  output logic                               stack_err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

  localparam int SP_BITS  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_BITS = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_CALL   = 3'd2;
  localparam logic [2:0] OP_RET    = 3'd3;
  localparam logic [2:0] OP_DECODE = 3'd4;
  localparam logic [2:0] OP_LDCNT  = 3'd5;
  localparam logic [2:0] OP_LOOP   = 3'd6;

  localparam logic [UPC_BITS-1:0] RESET_PC  = UPC_BITS'(RESET_ADDR);
  localparam logic [UPC_BITS-1:0] RESET_UPC = UPC_BITS'(RESET_ADDR - 1);
  localparam logic [UPC_BITS-1:0] INT_PC    = UPC_BITS'(INT_ADDR);
  localparam logic [SP_BITS-1:0]  SP_FULL   = SP_BITS'(STACK_DEPTH);

  logic [UPC_BITS-1:0] upc_q;
  logic [UPC_BITS-1:0] upc_next;
  logic [UPC_BITS-1:0] upc_inc;
  logic [UOP_BITS-1:0] uop_q;
  logic [SP_BITS-1:0]  sp_q;
  logic [SP_BITS-1:0]  sp_next;
  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_next;
  logic                err_q;
  logic                err_set;
  logic                push;
  logic                cond;
  logic [IDX_BITS-1:0] push_idx;
  logic [IDX_BITS-1:0] top_idx;
  logic [UPC_BITS-1:0] stack_mem [STACK_DEPTH];

  assign upc_inc  = upc_q + UPC_BITS'(1);
  assign cond     = (cond_mask == '0) ? 1'b1 : ((|(cond_mask & cond_in)) ^ cond_neg);
  assign push_idx = IDX_BITS'(sp_q);
  assign top_idx  = IDX_BITS'(sp_q - SP_BITS'(1));

  always_comb begin
    upc_next  = upc_inc;
    sp_next   = sp_q;
    cnt_next  = cnt_q;
    push      = 1'b0;
    err_set   = 1'b0;
    irq_taken = 1'b0;
    if (reset) begin
      upc_next = RESET_PC;
    end else if (busy) begin
      upc_next = upc_q;
    end else begin
      case (seq_op)
        OP_JUMP: if (cond) upc_next = seq_imm;
        OP_CALL: begin
          if (cond) begin
            upc_next = seq_imm;
            // A full stack still takes the jump; only the return address is lost.
            if (sp_q == SP_FULL) begin
              err_set = 1'b1;
            end else begin
              push    = 1'b1;
              sp_next = sp_q + SP_BITS'(1);
            end
          end
        end
        OP_RET: begin
          if (cond) begin
            if (sp_q == '0) begin
              err_set = 1'b1;
            end else begin
              sp_next  = sp_q - SP_BITS'(1);
              upc_next = stack_mem[top_idx];
            end
          end
        end
        OP_DECODE: begin
          upc_next  = irq ? INT_PC : decode_addr;
          irq_taken = irq;
        end
        OP_LDCNT: cnt_next = seq_imm[CNT_BITS-1:0];
        OP_LOOP: begin
          if (cnt_q != '0) begin
            cnt_next = cnt_q - CNT_BITS'(1);
            upc_next = seq_imm;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upc_q <= RESET_UPC;
      uop_q <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (!busy) begin
      upc_q <= upc_next;
      uop_q <= uop_rom_data;
      sp_q  <= sp_next;
      cnt_q <= cnt_next;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Push is already gated by reset and busy in the decode above.
  always_ff @(posedge clk) begin
    if (push) stack_mem[push_idx] <= upc_inc;
  end

  assign uop_rom_addr = upc_next;
  assign uop          = uop_q;
  assign upc          = upc_q;
  assign sp           = sp_q;
  assign stack_err    = err_q;

endmodule

// File: tb/tb_mesm6_useq.sv
// tb/tb_mesm6_useq.sv - vector table with scoreboard for mesm6_useq
module tb_mesm6_useq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy = 1'b0;
  logic [7:0]  uop_rom_addr;
  logic [63:0] uop_rom_data;
  logic [63:0] uop;
  logic [7:0]  upc;
  logic [2:0]  seq_op = 3'd0;
  logic [7:0]  seq_imm = 8'd0;
  logic [7:0]  cond_mask = 8'd0;
  logic        cond_neg = 1'b0;
  logic [7:0]  cond_in = 8'd0;
  logic        irq = 1'b0;
  logic [7:0]  decode_addr = 8'd0;
  logic        irq_taken;
  logic        stack_err;
  logic [2:0]  sp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] rom_f(input logic [7:0] a);
    return {a, ~a, 8'h5A, a ^ 8'h3C, 24'hC0DE00, a};
  endfunction

  assign uop_rom_data = rom_f(uop_rom_addr);

  mesm6_useq dut (
    .clk(clk), .reset(reset), .busy(busy),
    .uop_rom_addr(uop_rom_addr), .uop_rom_data(uop_rom_data),
    .uop(uop), .upc(upc),
    .seq_op(seq_op), .seq_imm(seq_imm),
    .cond_mask(cond_mask), .cond_neg(cond_neg), .cond_in(cond_in),
    .irq(irq), .decode_addr(decode_addr),
    .irq_taken(irq_taken), .stack_err(stack_err), .sp(sp)
  );

  typedef struct {
    logic       rst;
    logic       bsy;
    logic [2:0] op;
    logic [7:0] imm;
    logic [7:0] mask;
    logic       neg;
    logic [7:0] cin;
    logic       irq;
    logic [7:0] daddr;
    logic [7:0] e_addr;
    logic       e_irqt;
    logic [2:0] e_sp;
    logic       e_err;
  } vec_t;

  typedef struct {
    logic [7:0]  upc;
    logic [63:0] uop;
    logic [2:0]  sp;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic r, input logic b, input logic [2:0] op,
                              input logic [7:0] imm, input logic [7:0] mask,
                              input logic neg, input logic [7:0] cin, input logic iq,
                              input logic [7:0] da, input logic [7:0] ea,
                              input logic eiq, input logic [2:0] esp, input logic eerr);
    vec_t v;
    v.rst = r; v.bsy = b; v.op = op; v.imm = imm; v.mask = mask; v.neg = neg;
    v.cin = cin; v.irq = iq; v.daddr = da; v.e_addr = ea; v.e_irqt = eiq;
    v.e_sp = esp; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    reset = v.rst; busy = v.bsy; seq_op = v.op; seq_imm = v.imm;
    cond_mask = v.mask; cond_neg = v.neg; cond_in = v.cin;
    irq = v.irq; decode_addr = v.daddr;
    #1;
    chk($sformatf("v%0d rom_addr", idx), 64'(uop_rom_addr), 64'(v.e_addr));
    chk($sformatf("v%0d irq_taken", idx), 64'(irq_taken), 64'(v.e_irqt));
    e.upc = v.rst ? 8'd0 : v.e_addr;
    e.uop = v.rst ? 64'd0 : rom_f(e.upc);
    e.sp  = v.e_sp;
    e.err = v.e_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL v%0d scoreboard empty", idx);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d upc", idx), 64'(upc), 64'(e.upc));
      chk($sformatf("v%0d uop", idx), uop, e.uop);
      chk($sformatf("v%0d sp", idx), 64'(sp), 64'(e.sp));
      chk($sformatf("v%0d stack_err", idx), 64'(stack_err), 64'(e.err));
    end
    @(negedge clk);
  endtask

  initial begin
    //            rst bsy op  imm    mask   neg cin    irq daddr  e_addr irqt sp err
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h02, 0, 0, 0));
    vecs.push_back(mk(0, 0, 7, 8'h77, 8'h00, 0, 8'h00, 0, 8'h00, 8'h03, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h40, 8'h04, 0, 8'h00, 0, 8'h00, 8'h04, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h40, 8'h04, 0, 8'h04, 0, 8'h00, 8'h40, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h60, 8'h04, 1, 8'h04, 0, 8'h00, 8'h41, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h60, 8'h04, 1, 8'h00, 0, 8'h00, 8'h60, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h68, 8'hC0, 0, 8'h81, 0, 8'h00, 8'h68, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h10, 8'h00, 1, 8'h00, 0, 8'h00, 8'h10, 0, 0, 0));
    // nested call/return
    vecs.push_back(mk(0, 0, 2, 8'h80, 8'h00, 0, 8'h00, 0, 8'h00, 8'h80, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h81, 0, 1, 0));
    vecs.push_back(mk(0, 0, 2, 8'h90, 8'h00, 0, 8'h00, 0, 8'h00, 8'h90, 0, 2, 0));
    vecs.push_back(mk(0, 0, 3, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h82, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h11, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2, 8'hF0, 8'h01, 0, 8'h00, 0, 8'h00, 8'h12, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 8'h00, 8'h01, 0, 8'h00, 0, 8'h00, 8'h13, 0, 0, 0));
    // overflow then underflow
    vecs.push_back(mk(0, 0, 2, 8'hA0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hA0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 2, 8'hB0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hB0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 2, 8'hC0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hC0, 0, 3, 0));
    vecs.push_back(mk(0, 0, 2, 8'hD0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hD0, 0, 4, 0));
    vecs.push_back(mk(0, 0, 2, 8'hE0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hE0, 0, 4, 1));
    vecs.push_back(mk(0, 0, 3, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'hC1, 0, 3, 1));
    vecs.push_back(mk(0, 0, 3, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'hB1, 0, 2, 1));
    vecs.push_back(mk(0, 0, 3, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'hA1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h14, 0, 0, 1));
    vecs.push_back(mk(0, 0, 3, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h15, 0, 0, 1));
    // loop counter with a two-cycle stall
    vecs.push_back(mk(0, 0, 5, 8'h03, 8'h00, 0, 8'h00, 0, 8'h00, 8'h16, 0, 0, 1));
    vecs.push_back(mk(0, 0, 6, 8'h16, 8'h00, 0, 8'h00, 0, 8'h00, 8'h16, 0, 0, 1));
    vecs.push_back(mk(0, 0, 6, 8'h16, 8'h00, 0, 8'h00, 0, 8'h00, 8'h16, 0, 0, 1));
    vecs.push_back(mk(0, 1, 6, 8'h16, 8'h00, 0, 8'h00, 0, 8'h00, 8'h16, 0, 0, 1));
    vecs.push_back(mk(0, 1, 6, 8'h16, 8'h00, 0, 8'h00, 0, 8'h00, 8'h16, 0, 0, 1));
    vecs.push_back(mk(0, 0, 6, 8'h16, 8'h00, 0, 8'h00, 0, 8'h00, 8'h16, 0, 0, 1));
    vecs.push_back(mk(0, 0, 6, 8'h16, 8'h00, 0, 8'h00, 0, 8'h00, 8'h17, 0, 0, 1));
    vecs.push_back(mk(0, 0, 6, 8'h16, 8'h00, 0, 8'h00, 0, 8'h00, 8'h18, 0, 0, 1));
    // decode dispatch and interrupt entry
    vecs.push_back(mk(0, 0, 4, 8'h00, 8'h00, 0, 8'h00, 0, 8'h33, 8'h33, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4, 8'h00, 8'h00, 0, 8'h00, 1, 8'h50, 8'h02, 1, 0, 1));
    vecs.push_back(mk(0, 1, 4, 8'h00, 8'h00, 0, 8'h00, 1, 8'h50, 8'h02, 0, 0, 1));
    vecs.push_back(mk(0, 1, 4, 8'h00, 8'h00, 0, 8'h00, 1, 8'h50, 8'h02, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4, 8'h00, 8'h00, 0, 8'h00, 1, 8'h50, 8'h02, 1, 0, 1));
    vecs.push_back(mk(0, 0, 4, 8'h00, 8'h00, 0, 8'h00, 0, 8'h70, 8'h70, 0, 0, 1));
    vecs.push_back(mk(0, 0, 2, 8'h30, 8'h00, 0, 8'h00, 0, 8'h00, 8'h30, 0, 1, 1));
    vecs.push_back(mk(0, 0, 4, 8'h00, 8'h00, 0, 8'h00, 1, 8'h50, 8'h02, 1, 1, 1));
    vecs.push_back(mk(0, 0, 3, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h71, 0, 0, 1));
    // reset mid-call, then wrap-around
    vecs.push_back(mk(0, 0, 2, 8'h50, 8'h00, 0, 8'h00, 0, 8'h00, 8'h50, 0, 1, 1));
    vecs.push_back(mk(1, 0, 2, 8'h50, 8'h00, 0, 8'h00, 0, 8'h00, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'hFF, 8'h00, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h20, 8'h00, 0, 8'h00, 0, 8'h00, 8'h20, 0, 0, 0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // reset must win over busy, and suppress irq_taken
    reset = 1'b1; busy = 1'b1; seq_op = 3'd4; irq = 1'b1; decode_addr = 8'h44;
    #1;
    chk("rstbusy rom_addr", 64'(uop_rom_addr), 64'h01);
    chk("rstbusy irq_taken", 64'(irq_taken), 64'h0);
    @(posedge clk);
    #1;
    chk("rstbusy upc", 64'(upc), 64'h00);
    chk("rstbusy uop", uop, 64'h0);
    @(negedge clk);
    reset = 1'b0; busy = 1'b0; seq_op = 3'd0; irq = 1'b0;
    #1;
    chk("postrst rom_addr", 64'(uop_rom_addr), 64'h01);
    @(posedge clk);
    #1;
    chk("postrst upc", 64'(upc), 64'h01);
    chk("postrst uop", uop, rom_f(8'h01));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesm6_useq.md
Name: mesm6_useq

Overview:
Parametrised microprogram sequencer for next-generation MESM-6 cores. It generates the microcode ROM address and holds the registered microinstruction, with stall, decode dispatch and interrupt entry. It adds features the current inline sequencer lacks: a subroutine call/return stack, a hardware loop counter, N-way masked conditions with inversion, and a sticky stack error flag. It sits between the microcode ROM and the datapath; the core decodes `uop` fields and feeds sequencing controls back combinationally.

Parameters:
UPC_BITS, 8, microcode address width
UOP_BITS, 64, microinstruction width
NCOND, 8, number of condition inputs
STACK_DEPTH, 4, return stack entries (>=1)
CNT_BITS, 8, loop counter width (<= UPC_BITS)
RESET_ADDR, 1, first microinstruction executed after reset (>=1)
INT_ADDR, 2, interrupt entry microaddress

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous reset, active high
busy  in  1  stall: hold all state
uop_rom_addr  out  UPC_BITS  combinational ROM address (= upc_next)
uop_rom_data  in  UOP_BITS  ROM word at uop_rom_addr, combinational read
uop  out  UOP_BITS  registered microinstruction, always ROM[upc]
upc  out  UPC_BITS  address of current uop
seq_op  in  3  sequencing op of current uop
seq_imm  in  UPC_BITS  immediate target/count of current uop
cond_mask  in  NCOND  condition select mask
cond_neg  in  1  invert selected condition
cond_in  in  NCOND  live condition flags from datapath
irq  in  1  interrupt pending (already gated by core)
decode_addr  in  UPC_BITS  dispatch entry from core opcode tables
irq_taken  out  1  pulse: DECODE redirected to INT_ADDR
stack_err  out  1  sticky overflow/underflow flag
sp  out  $clog2(STACK_DEPTH+1)  stack occupancy

Behaviour:
- Reset (wins over busy): upc<=RESET_ADDR-1, uop<=0, sp<=0, cnt<=0, stack_err<=0, irq_taken<=0. uop_rom_addr=RESET_ADDR during reset. uop=0 decodes as NEXT, so the first post-reset cycle fetches ROM[RESET_ADDR].
- Each non-stalled cycle: upc<=upc_next, uop<=uop_rom_data.
- busy=1: upc_next=upc; upc, uop, sp, stack, cnt hold; no side effects; irq_taken=0.
- cond = (cond_mask==0) ? 1 : (|(cond_mask & cond_in)) ^ cond_neg.
- seq_op encoding:
  - 0 NEXT: upc+1.
  - 1 JUMP: cond ? seq_imm : upc+1.
  - 2 CALL: if cond, push upc+1 and target seq_imm; else upc+1.
  - 3 RET: if cond, pop and target the popped value; else upc+1.
  - 4 DECODE: irq ? INT_ADDR : decode_addr. irq_taken=1 for that cycle only when irq wins; cond ignored.
  - 5 LDCNT: cnt<=seq_imm[CNT_BITS-1:0], then upc+1.
  - 6 LOOP: cnt!=0 ? (cnt<=cnt-1, target seq_imm) : upc+1 with cnt held at 0. cond ignored.
  - 7: reserved, behaves as NEXT.
- upc+1 wraps modulo 2^UPC_BITS.
- Stack is LIFO, STACK_DEPTH entries.
  - CALL with sp==STACK_DEPTH: push dropped, jump still taken, stack_err<=1.
  - RET with sp==0: target upc+1, sp stays 0, stack_err<=1.
  - stack_err clears only on reset.
- irq_taken is combinational from the current uop/irq and qualified by ~busy.
- Stack and cnt are not cleared by DECODE or interrupt entry.

Test Plan:
- Reset, then NEXT,NEXT -> uop_rom_addr 1,2,3; upc 0 then 1 after first cycle; uop==ROM[upc] each cycle.
- JUMP seq_imm=0x40, cond_mask=0x04, cond_in[2]=0 then 1, cond_neg=0 -> first falls to upc+1, second goes to 0x40. With cond_neg=1 the outcomes swap.
- CALL 0x80 from upc 0x10, then nested CALL 0x90 from 0x81, then RET, RET -> returns to 0x82 then 0x11; sp 1,2,1,0.
- STACK_DEPTH=4: five CALLs -> stack_err=1 and sp=4. Four RETs unwind correctly; fifth RET goes to upc+1 with sp=0.
- LDCNT 3 then LOOP to its own address -> LOOP executes 4 times (3 taken, 1 fall-through), cnt ends 0. busy=1 asserted for 2 cycles mid-loop -> upc, cnt and uop frozen, total iterations unchanged.
- DECODE with irq=0, decode_addr=0x33 -> 0x33. DECODE with irq=1 -> INT_ADDR and one-cycle irq_taken. DECODE with irq=1 and busy=1 -> no redirect and irq_taken=0 until busy drops. Reset asserted mid-CALL -> sp=0, upc=RESET_ADDR-1 next cycle.
